// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the 7-segment display path (driver and scan decoder).
// Segment patterns are active-low, bit order g..a.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_NONE   = 4'hF;

    typedef enum logic {SETTLE, HOLD} state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } slot_t;

    // Maps an active-low one-hot anode value to a digit slot; anything else is invalid.
    function automatic slot_t an_slot(input logic [3:0] an);
        slot_t r;
        r = '0;
        case (an)
            4'b1110: r = '{valid: 1'b1, idx: 2'd0};
            4'b1101: r = '{valid: 1'b1, idx: 2'd1};
            4'b1011: r = '{valid: 1'b1, idx: 2'd2};
            4'b0111: r = '{valid: 1'b1, idx: 2'd3};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_if.sv
// Bundle of the scanned display bus and the recovered-digit outputs.
// master = display-side driver / consumer, slave = seven_seg_scan_decoder.
interface seven_seg_scan_decoder_if;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  seen;
    logic        frame_valid;
    logic        seg_err;
    logic        an_err;
    logic [3:0]  dp;

    modport master (
        output seg, an,
        input  digits, seen, frame_valid, seg_err, an_err, dp
    );

    modport slave (
        input  seg, an,
        output digits, seen, frame_valid, seg_err, an_err, dp
    );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational lookup from an active-low 7-segment pattern to its BCD value.
// Unknown patterns yield 4'hF with valid low.
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] value,
    output logic       valid
);

    always_comb begin
        value = 4'hF;
        valid = 1'b1;
        case (pattern)
            SEG_0:   value = 4'd0;
            SEG_1:   value = 4'd1;
            SEG_2:   value = 4'd2;
            SEG_3:   value = 4'd3;
            SEG_4:   value = 4'd4;
            SEG_5:   value = 4'd5;
            SEG_6:   value = 4'd6;
            SEG_7:   value = 4'd7;
            SEG_8:   value = 4'd8;
            SEG_9:   value = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers four BCD digits from a scanned, active-low seg/an display bus.
// Optional macro SEVEN_SEG_DECODER_DP_EN builds the decimal-point capture flops.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 8
) (
    input logic                      clk,
    input logic                      rst_n,
    seven_seg_scan_decoder_if.slave  bus
);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_chk_cnt
        $error("STABLE_CYCLES must be >= 2 and fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

    // {seg, an} synchronizer; all-ones is a blank display
    logic [11:0] sync_q [SYNC_STAGES];
    logic [11:0] s, s_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '1;
            s_q <= '1;
        end else begin
            sync_q[0] <= {bus.seg, bus.an};
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
            s_q <= s;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    logic [7:0] s_seg;
    logic [3:0] s_an;
    logic       changed;

    assign s_seg   = s[11:4];
    assign s_an    = s[3:0];
    assign changed = (s != s_q);

    // Stability FSM
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            SETTLE: begin
                if (changed) begin
                    cnt_d = '0;
                end else if (cnt_q == CntMax) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (changed) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    logic [3:0] dec_value;
    logic       dec_valid;

    seg_pattern_decode u_decode (
        .pattern (s_seg[6:0]),
        .value   (dec_value),
        .valid   (dec_valid)
    );

    slot_t slot;
    assign slot = an_slot(s_an);

    logic [15:0] digits_q, digits_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_q, frame_d;
    logic        seg_err_q, seg_err_d;
    logic        an_err_q, an_err_d;

    always_comb begin
        digits_d  = digits_q;
        seen_d    = seen_q;
        frame_d   = 1'b0;
        seg_err_d = seg_err_q;
        an_err_d  = 1'b0;
        // seen only reaches all-ones via a capture, and no capture can follow in the next cycle
        if (seen_q == 4'hF) begin
            seen_d  = '0;
            frame_d = 1'b1;
        end
        if (capture) begin
            if (slot.valid) begin
                digits_d[{slot.idx, 2'b00} +: 4] = dec_value;
                seen_d[slot.idx]                 = 1'b1;
                if (!dec_valid) seg_err_d = 1'b1;
            end else if (s_an != AN_NONE) begin
                an_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digits_q  <= '0;
            seen_q    <= '0;
            frame_q   <= 1'b0;
            seg_err_q <= 1'b0;
            an_err_q  <= 1'b0;
        end else begin
            digits_q  <= digits_d;
            seen_q    <= seen_d;
            frame_q   <= frame_d;
            seg_err_q <= seg_err_d;
            an_err_q  <= an_err_d;
        end
    end

`ifdef SEVEN_SEG_DECODER_DP_EN
    logic [3:0] dp_q, dp_d;

    always_comb begin
        dp_d = dp_q;
        if (capture && slot.valid) dp_d[slot.idx] = ~s_seg[7];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) dp_q <= '0;
        else        dp_q <= dp_d;
    end

    assign bus.dp = dp_q;
`else
    logic unused_dp_bit;
    assign unused_dp_bit = s_seg[7];
    assign bus.dp        = 4'b0000;
`endif

    assign bus.digits      = digits_q;
    assign bus.seen        = seen_q;
    assign bus.frame_valid = frame_q;
    assign bus.seg_err     = seg_err_q;
    assign bus.an_err      = an_err_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder with default parameters.
// Drives scanned seg/an sequences and checks recovered digits, flags and pulse counts.
module tb_seven_seg_scan_decoder;

    logic clk;
    logic rst_n;

    seven_seg_scan_decoder_if bus ();

    seven_seg_scan_decoder #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (16),
        .CNT_W         (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run;
    int tests_failed;
    int frame_cnt;
    int an_err_cnt;
    int frame_base;
    int an_err_base;

    initial begin
        frame_cnt  = 0;
        an_err_cnt = 0;
    end

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) frame_cnt++;
        if (bus.an_err === 1'b1) an_err_cnt++;
    end

`ifdef SEVEN_SEG_DECODER_DP_EN
    localparam logic [3:0] DpExp = 4'b1000;
`else
    localparam logic [3:0] DpExp = 4'b0000;
`endif

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] an, input logic [7:0] seg);
        bus.an  = an;
        bus.seg = seg;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        drive(4'hF, 8'hFF);
        step(3);

        check("reset_digits", bus.digits, 16'h0000);
        check("reset_seen", 16'(bus.seen), 16'h0);
        check("reset_frame", 16'(bus.frame_valid), 16'h0);
        check("reset_seg_err", 16'(bus.seg_err), 16'h0);
        check("reset_an_err", 16'(bus.an_err), 16'h0);
        check("reset_dp", 16'(bus.dp), 16'h0);

        // Single digit on slot 0: capture lands 19 edges after the drive
        rst_n = 1'b1;
        drive(4'b1110, 8'hF9);
        step(18);
        check("lat_before", bus.digits, 16'h0000);
        step(1);
        check("lat_at", bus.digits, 16'h0001);
        step(21);
        check("t1_seen", 16'(bus.seen), 16'h0001);
        check("t1_no_frame", 16'(frame_cnt), 16'd0);
        check("t1_no_an_err", 16'(an_err_cnt), 16'd0);

        // Full scan 0,5,2,1 across slots 0..3
        frame_base = frame_cnt;
        drive(4'b1110, 8'hC0);
        step(40);
        drive(4'b1101, 8'h92);
        step(40);
        drive(4'b1011, 8'hA4);
        step(40);
        check("scan_seen_partial", 16'(bus.seen), 16'h0007);
        check("scan_no_frame_yet", 16'(frame_cnt - frame_base), 16'd0);
        drive(4'b0111, 8'hF9);
        step(40);
        check("scan_digits", bus.digits, 16'h1250);
        check("scan_frame_once", 16'(frame_cnt - frame_base), 16'd1);
        check("scan_seen_clear", 16'(bus.seen), 16'h0);

        // Fast toggling never settles; only the final slot-1 value lands
        for (int i = 0; i < 6; i++) begin
            drive((i % 2 == 0) ? 4'b1110 : 4'b1101, 8'hB0);
            step(5);
        end
        drive(4'b1101, 8'hB0);
        step(40);
        check("glitch_digits", bus.digits, 16'h1230);
        check("glitch_seen", 16'(bus.seen), 16'h0002);

        // Two anodes active: one an_err pulse, no write
        an_err_base = an_err_cnt;
        drive(4'b1100, 8'hB0);
        step(40);
        check("an_err_once", 16'(an_err_cnt - an_err_base), 16'd1);
        check("an_err_digits", bus.digits, 16'h1230);
        check("an_err_seen", 16'(bus.seen), 16'h0002);
        check("an_err_no_seg_err", 16'(bus.seg_err), 16'h0);

        // Unknown pattern decodes to F and sets the sticky error
        drive(4'b1110, 8'h81);
        step(40);
        check("bad_seg_digits", bus.digits, 16'h123F);
        check("bad_seg_err", 16'(bus.seg_err), 16'h1);
        check("bad_seg_seen", 16'(bus.seen), 16'h0003);
        drive(4'b1110, 8'hC0);
        step(40);
        check("seg_err_sticky", 16'(bus.seg_err), 16'h1);
        check("recover_digits", bus.digits, 16'h1230);

        // Blank display produces no error
        an_err_base = an_err_cnt;
        drive(4'hF, 8'hFF);
        step(40);
        check("blank_no_an_err", 16'(an_err_cnt - an_err_base), 16'd0);

        // Reset in the middle of settling on slot 2
        drive(4'b1011, 8'h99);
        step(13);
        rst_n = 1'b0;
        step(1);
        check("midrst_digits", bus.digits, 16'h0000);
        check("midrst_seen", 16'(bus.seen), 16'h0);
        check("midrst_seg_err", 16'(bus.seg_err), 16'h0);
        check("midrst_frame", 16'(bus.frame_valid), 16'h0);
        check("midrst_an_err", 16'(bus.an_err), 16'h0);
        check("midrst_dp", 16'(bus.dp), 16'h0);
        rst_n = 1'b1;
        drive(4'hF, 8'hFF);
        step(40);
        check("midrst_no_write", bus.digits, 16'h0000);
        check("midrst_seen_after", 16'(bus.seen), 16'h0);

        // Digit 9 with decimal point lit on slot 3
        drive(4'b0111, 8'h10);
        step(40);
        check("dp_digits", bus.digits, 16'h9000);
        check("dp_seen", 16'(bus.seen), 16'h0008);
        check("dp_value", 16'(bus.dp), 16'(DpExp));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
